// File: rtl/median_filter_var.sv
// Running median over a run-time selectable window.
// Sorted array is updated by a one-cycle systolic insert/remove.
module median_filter_var #(
  parameter int DATA_LENGTH = 32,
  parameter int WMAX        = 16,
  parameter int LOG_WMAX    = 5,
  parameter int SIGNED_CMP  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LOG_WMAX-1:0]    W,
  input  logic                   w_load,
  input  logic [DATA_LENGTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_LENGTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   w_err,
  output logic                   full
);

  typedef logic [DATA_LENGTH-1:0] data_t;
  typedef enum logic {FILL, RUN} state_t;

  state_t state;
  data_t s    [WMAX];
  data_t a    [WMAX];
  data_t s_nx [WMAX];
  data_t sl   [WMAX];
  data_t sr   [WMAX];

  logic [LOG_WMAX-1:0] cnt, w_eff, w_clamp;
  logic clamp_err, acc, run, fill_done;
  logic found, r_ge;
  data_t oldest, med;
  int ge_n, r_i, p_i, n_i, we_i, m_i;

  function automatic logic ge(input data_t x, input data_t y);
    if (SIGNED_CMP != 0) return $signed(x) >= $signed(y);
    return x >= y;
  endfunction

  assign run       = (state == RUN);
  assign in_ready  = reset && !w_load && (!out_valid || out_ready);
  assign acc       = in_valid && in_ready;
  assign full      = (cnt == w_eff);
  assign fill_done = ((cnt + LOG_WMAX'(1)) == w_eff);

  always_comb begin
    w_clamp   = W;
    clamp_err = 1'b0;
    if (W == '0) begin
      w_clamp   = LOG_WMAX'(1);
      clamp_err = 1'b1;
    end else if (W > LOG_WMAX'(WMAX)) begin
      w_clamp   = LOG_WMAX'(WMAX);
      clamp_err = 1'b1;
    end
  end

  // r_i: slot vacated by the oldest sample (cnt while filling),
  // p_i: slot the new sample lands in after that removal.
  always_comb begin
    n_i    = int'(cnt);
    we_i   = int'(w_eff);
    m_i    = (we_i - 1) / 2;
    oldest = a[0];
    med    = '0;
    ge_n   = 0;
    found  = 1'b0;
    r_ge   = 1'b0;
    for (int i = 0; i < WMAX; i++)
      if (i == we_i - 1) oldest = a[i];
    for (int i = 0; i < WMAX; i++)
      if (i < n_i && ge(s[i], in_data)) ge_n = ge_n + 1;
    r_i = n_i;
    if (run) begin
      r_i = we_i - 1;
      for (int i = 0; i < WMAX; i++)
        if (!found && i < we_i && s[i] == oldest) begin
          r_i   = i;
          r_ge  = ge(s[i], in_data);
          found = 1'b1;
        end
    end
    p_i = ge_n - (r_ge ? 1 : 0);
    sl[0]      = '0;
    sr[WMAX-1] = '0;
    for (int i = 1; i < WMAX; i++) sl[i] = s[i-1];
    for (int i = 0; i < WMAX - 1; i++) sr[i] = s[i+1];
    for (int i = 0; i < WMAX; i++) begin
      s_nx[i] = s[i];
      if (i == p_i)
        s_nx[i] = in_data;
      else if (p_i <= r_i && i > p_i && i <= r_i)
        s_nx[i] = sl[i];
      else if (p_i > r_i && i >= r_i && i < p_i)
        s_nx[i] = sr[i];
    end
    for (int i = 0; i < WMAX; i++)
      if (i == m_i) med = s_nx[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      cnt       <= '0;
      w_eff     <= LOG_WMAX'(WMAX);
      w_err     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < WMAX; i++) begin
        s[i] <= '0;
        a[i] <= '0;
      end
    end else if (w_load) begin
      state     <= FILL;
      cnt       <= '0;
      w_eff     <= w_clamp;
      w_err     <= clamp_err;
      out_valid <= 1'b0;
      for (int i = 0; i < WMAX; i++) begin
        s[i] <= '0;
        a[i] <= '0;
      end
    end else begin
      if (acc) begin
        for (int i = 0; i < WMAX; i++) s[i] <= s_nx[i];
        a[0] <= in_data;
        for (int i = 1; i < WMAX; i++) a[i] <= a[i-1];
        if (!run) cnt <= cnt + LOG_WMAX'(1);
        if (run || fill_done) state <= RUN;
      end
      if (acc && (run || fill_done)) begin
        out_data  <= med;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_median_filter_var.sv
// Directed bench for median_filter_var: vector table plus
// hand sequences for backpressure, signed compare and reset.
module tb_median_filter_var;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  W;
  logic        w_load;
  logic [31:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready, out_valid, w_err, full;
  logic [31:0] out_data;
  logic        in_ready_s, out_valid_s, w_err_s, full_s;
  logic [31:0] out_data_s;

  int nvec = 0;
  int nbad = 0;

  typedef struct {
    logic        ld;
    logic [4:0]  w;
    logic        v;
    logic [31:0] d;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
    logic        ef;
  } vec_t;

  vec_t tbl[$];

  median_filter_var #(.DATA_LENGTH(32), .WMAX(16), .LOG_WMAX(5),
                      .SIGNED_CMP(0)) dut (
    .clk(clk), .reset(reset), .W(W), .w_load(w_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .w_err(w_err), .full(full));

  median_filter_var #(.DATA_LENGTH(32), .WMAX(16), .LOG_WMAX(5),
                      .SIGNED_CMP(1)) dut_s (
    .clk(clk), .reset(reset), .W(W), .w_load(w_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s),
    .out_data(out_data_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .w_err(w_err_s), .full(full_s));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic [4:0] w,
                     input logic v, input logic [31:0] d,
                     input logic ev, input logic [31:0] ed,
                     input logic ee, input logic ef);
    vec_t r;
    r.ld = ld; r.w = w; r.v = v; r.d = d;
    r.ev = ev; r.ed = ed; r.ee = ee; r.ef = ef;
    tbl.push_back(r);
  endtask

  task automatic step(input logic l, input logic [4:0] ww,
                      input logic v, input logic [31:0] dd,
                      input logic rd);
    w_load = l; W = ww; in_valid = v; in_data = dd; out_ready = rd;
    @(posedge clk);
    #1;
    w_load = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; W = '0; w_load = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;

    // W=3, with a sample colliding with w_load (must be dropped)
    add(1, 3, 1, 99, 0, 0, 0, 0);
    add(0, 0, 1, 5,  0, 0, 0, 0);
    add(0, 0, 1, 1,  0, 0, 0, 0);
    add(0, 0, 1, 9,  1, 5, 0, 1);
    add(0, 0, 1, 4,  1, 4, 0, 1);
    add(0, 0, 1, 4,  1, 4, 0, 1);
    // W=4, upper median, then idle clears out_valid
    add(1, 4, 0, 0,  0, 0,  0, 0);
    add(0, 0, 1, 10, 0, 0,  0, 0);
    add(0, 0, 1, 20, 0, 0,  0, 0);
    add(0, 0, 1, 30, 0, 0,  0, 0);
    add(0, 0, 1, 40, 1, 30, 0, 1);
    add(0, 0, 1, 50, 1, 40, 0, 1);
    add(0, 0, 0, 0,  0, 0,  0, 1);
    // W=3 duplicates
    add(1, 3, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 7, 0, 0, 0, 0);
    add(0, 0, 1, 7, 0, 0, 0, 0);
    add(0, 0, 1, 7, 1, 7, 0, 1);
    add(0, 0, 1, 2, 1, 7, 0, 1);
    add(0, 0, 1, 7, 1, 7, 0, 1);
    add(0, 0, 1, 2, 1, 2, 0, 1);
    add(0, 0, 1, 2, 1, 2, 0, 1);
    // W=0 clamps to 1
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 8, 1, 8, 1, 1);
    add(0, 0, 1, 3, 1, 3, 1, 1);
    add(0, 0, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, 1);
    // W=19 clamps to 16
    add(1, 19, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 15; i++)
      add(0, 0, 1, i, 0, 0, 1, 0);
    add(0, 0, 1, 16, 1, 9,  1, 1);
    add(0, 0, 1, 17, 1, 10, 1, 1);
    // W=16 is in range
    add(1, 16, 0, 0, 0, 0, 0, 0);
    add(0, 0,  1, 5, 0, 0, 0, 0);

    #2 reset = 1'b0;
    #2;
    chk("rst_ovld", 0, out_valid, 0);
    chk("rst_full", 0, full, 0);
    chk("rst_werr", 0, w_err, 0);
    chk("rst_irdy", 0, in_ready, 0);
    chk("rst_odat", 0, out_data, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rel_irdy", 0, in_ready, 1);

    foreach (tbl[k]) begin
      step(tbl[k].ld, tbl[k].w, tbl[k].v, tbl[k].d, 1'b1);
      chk("ovld", k, out_valid, tbl[k].ev);
      if (tbl[k].ev) chk("odat", k, out_data, tbl[k].ed);
      chk("werr", k, w_err, tbl[k].ee);
      chk("full", k, full, tbl[k].ef);
    end

    // backpressure
    step(1, 3, 0, 0, 1);
    step(0, 0, 1, 5, 1);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 9, 1);
    chk("bp_first", 0, out_data, 5);
    in_valid = 1'b1; in_data = 4; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_irdy", k, in_ready, 0);
      @(posedge clk);
      #1;
      chk("bp_ovld", k, out_valid, 1);
      chk("bp_odat", k, out_data, 5);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_irdy", 0, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_rel_ovld", 0, out_valid, 1);
    chk("bp_rel_odat", 0, out_data, 4);
    step(0, 0, 0, 0, 1);
    chk("bp_clr", 0, out_valid, 0);

    // signed vs unsigned compare
    step(1, 3, 0, 0, 1);
    step(0, 0, 1, 32'hFFFF_FFFF, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 1, 1);
    chk("sg_ovld", 0, out_valid_s, 1);
    chk("sg_odat", 0, out_data_s, 0);
    chk("sg_full", 0, full_s, 1);
    chk("sg_werr", 0, w_err_s, 0);
    chk("us_odat", 0, out_data, 1);

    // reset mid-stream
    step(0, 0, 1, 5, 1);
    chk("mid_pre", 0, out_valid, 1);
    reset = 1'b0;
    #1;
    chk("mid_ovld", 0, out_valid, 0);
    chk("mid_ovld_s", 0, out_valid_s, 0);
    chk("mid_full", 0, full, 0);
    chk("mid_irdy", 0, in_ready_s, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rel_irdy", 0, in_ready, 1);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 3 * i, 1);
      chk("refill_ovld", i, out_valid, (i == 16) ? 1 : 0);
      if (i == 16) begin
        chk("refill_odat", i, out_data, 27);
        chk("refill_full", i, full, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/median_filter_var.md
MEDIAN_FILTER_VAR -- requirements
Module: median_filter_var

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 32, meaning sample width in bits.
REQ-002 SHALL have parameter WMAX, default 16, meaning maximum window length (number of sort cells).
REQ-003 SHALL have parameter LOG_WMAX, default 5, meaning width of window-size and count fields; it SHALL satisfy 2^LOG_WMAX > WMAX.
REQ-004 SHALL have parameter SIGNED_CMP, default 0, meaning 0 = unsigned and 1 = two's-complement sample compare.
REQ-005 SHALL have ports:
  clk  input  1  clock; all state updates on its rising edge.
  reset  input  1  asynchronous, active-low reset.
  W  input  LOG_WMAX  requested window length; sampled only on w_load.
  w_load  input  1  pulse that latches W and flushes the window.
  in_data  input  DATA_LENGTH  input sample.
  in_valid  input  1  in_data is valid.
  in_ready  output  1  block accepts a sample this cycle.
  out_data  output  DATA_LENGTH  median value.
  out_valid  output  1  out_data is valid.
  out_ready  input  1  downstream accepts out_data.
  w_err  output  1  last latched W was out of range (sticky until next w_load).
  full  output  1  window holds W_eff samples.

Function
REQ-006 SHALL keep a sorted array S[0..WMAX-1], descending (S[0] largest), plus an arrival-order FIFO A of WMAX entries.
REQ-007 SHALL keep an effective window W_eff and an occupancy count cnt (0..W_eff).
REQ-008 A sample SHALL be accepted when in_valid && in_ready.
REQ-009 in_ready SHALL = !w_load && (!out_valid || out_ready).
REQ-010 On w_load: W_eff SHALL become W, clamped to 1 if W==0 and to WMAX if W>WMAX.
REQ-011 On w_load: w_err SHALL be set iff clamping occurred.
REQ-012 On w_load: cnt, S, A and out_valid SHALL be cleared.
REQ-013 w_load SHALL take priority over any simultaneous input sample; that sample is not accepted.
REQ-014 Two states SHALL exist. FILL while cnt<W_eff: an accepted sample is inserted into S and A, and cnt increments.
REQ-015 RUN while cnt==W_eff: an accepted sample is inserted, the oldest A entry is removed from S, and cnt is unchanged. Transition FILL->RUN occurs when cnt reaches W_eff; RUN->FILL occurs only on w_load.
REQ-016 Insertion SHALL place the new sample after all existing entries >= it, so equal values keep arrival order.
REQ-017 Removal SHALL delete exactly one entry equal to the oldest value: the lowest-index match.
REQ-018 Insert and remove SHALL complete together in a single cycle (systolic shift: each cell chooses hold, take left neighbour, take right neighbour, or take in_data).
REQ-019 After the cycle in which an accepted sample makes or keeps cnt==W_eff, out_data SHALL be registered as S[(W_eff-1)/2] of the updated array. For even W_eff this is the upper median. out_valid SHALL assert in the next cycle, giving 1-cycle latency.
REQ-020 No output SHALL be produced during FILL before cnt reaches W_eff.
REQ-021 out_valid and out_data SHALL hold stable while out_valid && !out_ready.
REQ-022 out_valid SHALL clear on out_ready when no new median is produced in that cycle.
REQ-023 Entries at index >= W_eff SHALL be ignored by comparison and median selection.
REQ-024 Comparison SHALL follow SIGNED_CMP; no arithmetic is performed on samples.
REQ-025 full SHALL = (cnt==W_eff).

Reset
REQ-026 reset low SHALL asynchronously clear S, A, cnt, out_data, out_valid, w_err and full to 0, and set W_eff to WMAX.
REQ-027 in_ready SHALL be 0 while reset is low and 1 in the first cycle after release (no w_load, out_valid=0).
REQ-028 reset asserted mid-stream SHALL discard all samples and any pending output.

Verification
REQ-029 W=3 loaded, samples 5,1,9,4,4 with out_ready=1 -> no output for the first two samples; then medians 5,4,4, each one cycle after acceptance.
REQ-030 W=4, samples 10,20,30,40,50 -> outputs 30 (after 40) and 40 (after 50), confirming upper median.
REQ-031 W=3, samples 7,7,7,2,7 -> outputs 7,7,7, confirming duplicate removal leaves exactly one instance per sample.
REQ-032 out_ready held 0 for 5 cycles with out_valid=1 -> out_data stable and in_ready=0; on release, the next sample is accepted in the same cycle.
REQ-033 W=0 and W=WMAX+3 loaded -> w_err=1 and W_eff=1 and WMAX respectively; with W_eff=1 each output equals the preceding input.
REQ-034 SIGNED_CMP=1, W=3, samples -1,0,1 -> output 0. reset pulsed low mid-stream -> out_valid=0 immediately, and the next W samples produce no output until the window refills.
